pll_phase_stepper: RTL
======================

Name: pll_phase_stepper

Overview:
- Control companion for an ECP5 EHXPLLL instance.
- Sequences PLL reset and lock acquisition, and debounces LOCK.
- Gates a system reset until lock is stable.
- Executes queued dynamic fine-phase shift requests on up to four PLL outputs through PHASESEL/PHASEDIR/PHASESTEP, and tracks each channel's current phase offset.
- Sits next to the PLL wrapper in the board top level and is clocked by the PLL reference clock.

Parameters:
- NUM_CH, 4, number of steerable outputs (1..4); channel 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3.
- PHASE_MOD, 64, fine steps per output period (8*CLKx_DIV); position wraps modulo this.
- PHASE_W, 8, width of each tracked phase position (must satisfy PHASE_MOD <= 2^PHASE_W).
- CNT_W, 8, width of request step count.
- RST_CYCLES, 16, cycles pll_rst is held high.
- LOCK_FILTER, 1024, consecutive synchronised-lock cycles required before locked=1.
- LOCK_TIMEOUT, 65536, cycles in WAIT_LOCK before retrying the PLL reset.
- SETUP_CYCLES, 4, cycles PHASESEL/PHASEDIR are stable before a step pulse.
- STEP_LOW, 4, cycles phase_step is held low per step.
- HOLD_CYCLES, 4, cycles phase_step is held high after each pulse.

Ports:
- clock  in  1  reference clock (25 MHz typical).
- reset  in  1  synchronous, active-high.
- pll_lock_in  in  1  raw EHXPLLL LOCK, asynchronous to clock.
- req_valid  in  1  phase-shift request valid.
- req_ready  out  1  block can accept a request.
- req_ch  in  2  target channel.
- req_dir  in  1  1=advance (+1 per step), 0=delay (-1 per step).
- req_count  in  CNT_W  number of fine steps.
- req_err  out  1  one-cycle pulse when a request names a channel >= NUM_CH.
- pll_rst  out  1  to EHXPLLL RST.
- phase_sel  out  2  to PHASESEL[1:0].
- phase_dir  out  1  to PHASEDIR.
- phase_step  out  1  to PHASESTEP; idles high.
- locked  out  1  filtered lock.
- sys_reset  out  1  synchronous reset for downstream logic.
- busy  out  1  a phase request is executing.
- phase_pos  out  NUM_CH*PHASE_W  current offset per channel; channel i occupies bits [i*PHASE_W +: PHASE_W].

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Values while reset=1: pll_rst=1, phase_step=1, phase_sel=2'b11, phase_dir=0, locked=0, sys_reset=1, req_ready=0, busy=0, req_err=0, every phase_pos=0. State=RST_PLL with the cycle counter cleared.
- Lock synchronisation: pll_lock_in passes through a 2-flop synchroniser to give lk.
- Lock filter: a counter counts consecutive lk=1 cycles. locked rises on the cycle the count reaches LOCK_FILTER. locked falls on the first cycle lk=0.
- sys_reset = !locked, registered.
- State machine:
  - RST_PLL: pll_rst=1 for RST_CYCLES cycles, then WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0. Go to IDLE when locked=1. Go back to RST_PLL after LOCK_TIMEOUT cycles without lock.
  - IDLE: req_ready=1. When req_valid=1 the request is accepted in that cycle: ch/dir/count are latched and the next state is SETUP.
  - SETUP: phase_sel and phase_dir are driven; stay SETUP_CYCLES cycles, then STEP.
  - STEP: phase_step=0 for STEP_LOW cycles, then HOLD.
  - HOLD: phase_step=1 for HOLD_CYCLES cycles. Then decrement the remaining count: if it is non-zero go to STEP, otherwise go to IDLE.
- busy=1 in SETUP, STEP and HOLD.
- Channel to phase_sel mapping: ch0->2'b11, ch1->2'b00, ch2->2'b01, ch3->2'b10. phase_sel/phase_dir stay constant from SETUP until the return to IDLE.
- Position update: on each STEP->HOLD transition, phase_pos[ch] changes by ±1 modulo PHASE_MOD.
  - Advance wraps PHASE_MOD-1 -> 0.
  - Delay wraps 0 -> PHASE_MOD-1.
- req_count=0: the request is accepted and no pulse is issued. Next cycle the state is IDLE and positions are unchanged.
- Invalid channel (req_ch >= NUM_CH): the request is accepted, req_err pulses on the following cycle, the state stays IDLE and no outputs change.
- Loss of lock (locked falls in IDLE/SETUP/STEP/HOLD):
  - Next state is RST_PLL, phase_step is forced to 1 immediately, and any in-flight request is abandoned.
  - All phase_pos clear to 0, because the PLL reset restores the static phase.
  - req_ready=0 until IDLE is reached again.
- req_valid arriving while busy is ignored (req_ready=0); the requester must hold it.
- reset asserted mid-request: everything returns to its reset values on the next edge and no partial pulse continues.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - the state enum;
  - the channel-to-PHASESEL mapping constants;
  - the default timing constants.
- Natural sub-module: pll_lock_filter (2-flop synchroniser plus consecutive-cycle counter, outputs locked), reusable by other PLL wrappers.

Test Plan:
- Lock bring-up: reset 2 cycles; pll_lock_in rises 100 cycles after pll_rst falls -> pll_rst high exactly 16 cycles; locked and sys_reset=0 exactly 2+1024 cycles after the lock rises (+1 for the registered sys_reset); req_ready=1.
- Single step: ch=1, dir=1, count=1 -> phase_sel=2'b00 and phase_dir=1 for 4 cycles before the pulse; phase_step low exactly 4 cycles; phase_pos[1]=1; busy for 12 cycles.
- Wrap and multi-step: ch=0, dir=0, count=3 from pos 0 with PHASE_MOD=64 -> 3 pulses spaced 8 cycles apart; phase_pos[0]=61; phase_sel=2'b11 throughout.
- Boundaries: count=0 -> no pulse and busy never asserts; NUM_CH=2 with ch=3 -> req_err one-cycle pulse, no pulse, positions unchanged.
- Lock loss during the 2nd of 5 pulses -> phase_step returns high within 3 cycles (2-flop synchroniser plus one cycle); pll_rst pulses 16 cycles; all phase_pos=0; sys_reset=1 until relock.
- Timeout: pll_lock_in never asserts -> pll_rst re-pulses every 16+65536 cycles; locked stays 0.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 PLL control companion:
// sequencer states, channel-to-PHASESEL encoding and default timings.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_STEP,
    ST_HOLD
  } state_e;

  // PHASESEL encodings of the EHXPLLL outputs
  localparam logic [1:0] SEL_CLKOP  = 2'b11;
  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;

  localparam int unsigned DEF_NUM_CH       = 4;
  localparam int unsigned DEF_PHASE_MOD    = 64;
  localparam int unsigned DEF_PHASE_W      = 8;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_RST_CYCLES   = 16;
  localparam int unsigned DEF_LOCK_FILTER  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT = 65536;
  localparam int unsigned DEF_SETUP_CYCLES = 4;
  localparam int unsigned DEF_STEP_LOW     = 4;
  localparam int unsigned DEF_HOLD_CYCLES  = 4;

  function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
    case (ch)
      2'd0:    return SEL_CLKOP;
      2'd1:    return SEL_CLKOS;
      2'd2:    return SEL_CLKOS2;
      default: return SEL_CLKOS3;
    endcase
  endfunction

endpackage

// File: rtl/pll_phase_stepper_if.sv
// Phase-shift request channel: requester drives the request, the stepper
// answers with ready and a one-cycle error pulse for bad channel numbers.
interface pll_phase_stepper_if #(
  parameter int unsigned CNT_W = pll_ctrl_pkg::DEF_CNT_W
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_ch;
  logic             req_dir;
  logic [CNT_W-1:0] req_count;
  logic             req_err;

  modport master (
    output req_valid, req_ch, req_dir, req_count,
    input  req_ready, req_err
  );

  modport slave (
    input  req_valid, req_ch, req_dir, req_count,
    output req_ready, req_err
  );
endinterface

// File: rtl/pll_lock_filter.sv
// Synchronises a raw PLL LOCK and qualifies it over LOCK_FILTER consecutive cycles.
// A drop is seen one stage early so locked falls together with the synchronised lock.
module pll_lock_filter import pll_ctrl_pkg::*; #(
  parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic clock,
  input  logic reset,
  input  logic lock_in,
  output logic locked
);
  localparam int unsigned FCNT_W = $clog2(LOCK_FILTER + 1);

  logic              sync1_q;
  logic              lk_q;
  logic [FCNT_W-1:0] cnt_q;
  logic [FCNT_W-1:0] cnt_d;
  logic              locked_q;

  // Saturating count of consecutive synchronised-lock cycles
  always_comb begin
    cnt_d = cnt_q;
    if (!lk_q) begin
      cnt_d = '0;
    end else if (cnt_q != FCNT_W'(LOCK_FILTER)) begin
      cnt_d = cnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lk_q     <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      sync1_q  <= lock_in;
      lk_q     <= sync1_q;
      cnt_q    <= cnt_d;
      locked_q <= sync1_q && (cnt_d == FCNT_W'(LOCK_FILTER));
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/pll_phase_stepper.sv
// EHXPLLL companion: PLL reset/lock sequencing, system reset gating and
// queued fine-phase stepping with per-channel phase position tracking.
module pll_phase_stepper import pll_ctrl_pkg::*; #(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned PHASE_MOD    = DEF_PHASE_MOD,
  parameter int unsigned PHASE_W      = DEF_PHASE_W,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned STEP_LOW     = DEF_STEP_LOW,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pll_lock_in,
  pll_phase_stepper_if.slave        req,
  output logic                      pll_rst,
  output logic [1:0]                phase_sel,
  output logic                      phase_dir,
  output logic                      phase_step,
  output logic                      locked,
  output logic                      sys_reset,
  output logic                      busy,
  output logic [NUM_CH*PHASE_W-1:0] phase_pos
);
  localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT) + 1;

  state_e             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   rem_q;
  logic [1:0]         ch_q;
  logic [PHASE_W-1:0] pos_q [NUM_CH];
  logic               pll_rst_q;
  logic [1:0]         sel_q;
  logic               dir_q;
  logic               step_q;
  logic               ready_q;
  logic               err_q;
  logic               busy_q;
  logic               sys_reset_q;
  logic               lock_ok;

  function automatic logic [PHASE_W-1:0] step_pos(input logic [PHASE_W-1:0] p,
                                                  input logic adv);
    if (adv) return (p == PHASE_W'(PHASE_MOD - 1)) ? '0 : p + PHASE_W'(1);
    return (p == '0) ? PHASE_W'(PHASE_MOD - 1) : p - PHASE_W'(1);
  endfunction

  pll_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
    .clock   (clock),
    .reset   (reset),
    .lock_in (pll_lock_in),
    .locked  (lock_ok)
  );

  always_ff @(posedge clock) begin
    err_q       <= 1'b0;
    sys_reset_q <= !lock_ok;
    if (reset) begin
      state_q     <= ST_RST_PLL;
      tmr_q       <= '0;
      rem_q       <= '0;
      ch_q        <= '0;
      pll_rst_q   <= 1'b1;
      sel_q       <= SEL_CLKOP;
      dir_q       <= 1'b0;
      step_q      <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      sys_reset_q <= 1'b1;
      for (int i = 0; i < int'(NUM_CH); i++) pos_q[i] <= '0;
    end else if ((state_q inside {ST_IDLE, ST_SETUP, ST_STEP, ST_HOLD}) && !lock_ok) begin
      // PLL reset restores the static phase, so tracked offsets are cleared too
      state_q   <= ST_RST_PLL;
      tmr_q     <= '0;
      pll_rst_q <= 1'b1;
      step_q    <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) pos_q[i] <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
      case (state_q)
        ST_RST_PLL: begin
          if (tmr_q == TMR_W'(RST_CYCLES - 1)) begin
            state_q   <= ST_WAIT_LOCK;
            pll_rst_q <= 1'b0;
            tmr_q     <= '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            tmr_q   <= '0;
          end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
            state_q   <= ST_RST_PLL;
            pll_rst_q <= 1'b1;
            tmr_q     <= '0;
          end
        end
        ST_IDLE: begin
          tmr_q <= '0;
          if (req.req_valid) begin
            if (32'(req.req_ch) >= NUM_CH) begin
              err_q <= 1'b1;
            end else if (req.req_count != '0) begin
              state_q <= ST_SETUP;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              ch_q    <= req.req_ch;
              sel_q   <= ch_to_sel(req.req_ch);
              dir_q   <= req.req_dir;
              rem_q   <= req.req_count;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_q == TMR_W'(SETUP_CYCLES - 1)) begin
            state_q <= ST_STEP;
            step_q  <= 1'b0;
            tmr_q   <= '0;
          end
        end
        ST_STEP: begin
          if (tmr_q == TMR_W'(STEP_LOW - 1)) begin
            state_q <= ST_HOLD;
            step_q  <= 1'b1;
            tmr_q   <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
              if (ch_q == 2'(i)) pos_q[i] <= step_pos(pos_q[i], dir_q);
            end
          end
        end
        ST_HOLD: begin
          if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
            tmr_q <= '0;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_STEP;
              step_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= ST_RST_PLL;
          pll_rst_q <= 1'b1;
          tmr_q     <= '0;
        end
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign req.req_err   = err_q;
  assign pll_rst       = pll_rst_q;
  assign phase_sel     = sel_q;
  assign phase_dir     = dir_q;
  assign phase_step    = step_q;
  assign locked        = lock_ok;
  assign sys_reset     = sys_reset_q;
  assign busy          = busy_q;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_pos
    assign phase_pos[g*PHASE_W +: PHASE_W] = pos_q[g];
  end

endmodule
